uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one `uart_tx` transmitter among four byte producers. It sits between the control-side producers (gate-command, status and debug sources) and the UART transmitter. It arbitrates pending requests and, when enabled, prefixes each payload byte with a header byte identifying the source. It drives the transmitter's start/data handshake, holding `tx_start` until `tx_busy` confirms acceptance, and reports completion or timeout back to the requester.

## Interface
- `HEADER_EN`, 1, 1: send header byte before each payload byte; 0: payload only.
- `HDR_TAG`, 6'b101000, upper 6 bits of the header byte; header = {HDR_TAG, grant_id}.
- `TIMEOUT_CYC`, 255, max clk cycles `tx_start` is held without `tx_busy` rising (8-bit counter; legal 1..255).

- `clk`  in  1  system clock (same clock that feeds the transmitter's baud divider).
- `reset`  in  1  reset, synchronous, active-low.
- `req`  in  4  per-source request; held high until the matching `ack` or `err_timeout`.
- `req_data`  in  32  payload bytes; source i on bits [8i+7:8i].
- `ack`  out  4  one-hot, 1-cycle pulse: source's byte fully transmitted.
- `tx_data`  out  8  byte to transmitter `data_to_tx`.
- `tx_start`  out  1  to transmitter `start_tx`.
- `tx_busy`  in  1  from transmitter `tx_busy`.
- `grant_id`  out  2  currently served source; valid while `active`.
- `active`  out  1  high from LOAD through ACK.
- `err_timeout`  out  1  1-cycle pulse: transmitter never accepted a byte.

## Operation
- States: IDLE, LOAD, START, BUSY, ACK.
- IDLE: if `tx_busy`==0 and `req`!=0, pick the winner and go to LOAD. Otherwise stay in IDLE. A high `tx_busy` blocks granting, which covers a frame left running across a reset.
- Arbitration: round-robin. Search starts at `last+1` and proceeds mod 4. `last` resets to 3, so source 0 wins first. `last` updates to the winner on entering LOAD.
- LOAD (1 cycle):
  - Latch `req_data` of the winner into the payload register.
  - Set `phase` = HEADER if `HEADER_EN`, else PAYLOAD.
  - Drive `tx_data` = header or payload accordingly.
  - Clear the timeout counter. Go to START.
- START:
  - `tx_start`=1 and `tx_data` stays stable.
  - On `tx_busy`==1: drop `tx_start` and go to BUSY.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYC`: drop `tx_start`, pulse `err_timeout`, no `ack`, go to IDLE. `last` keeps the winner.
- BUSY: wait for `tx_busy`==0.
  - If `phase`==HEADER: set `phase`=PAYLOAD, `tx_data`=payload, clear the counter, go to START.
  - Otherwise go to ACK.
- ACK (1 cycle): `ack[grant_id]`=1, then go to IDLE.
- `req` deasserted mid-transfer is ignored. The latched transfer completes and still acks.
- `req_data` is sampled only in LOAD. The source may change it after LOAD.

## Timing
- Reset values: `ack`=0, `tx_data`=0, `tx_start`=0, `grant_id`=0, `active`=0, `err_timeout`=0, state IDLE, `last`=3, counter=0.
- Reset asserted in any state: all outputs return to reset values on the next `clk` edge. The transmitter may finish its current frame; IDLE waits for it.
- All outputs are registered.
- `req` rising to `active` high: 1 cycle. LOAD to `tx_start` high: 1 cycle.
- `tx_start` falls the cycle after `tx_busy` is sampled high.
- `ack` is asserted 1 cycle after `tx_busy` is sampled low for the payload byte.
- Back-to-back: from ACK, IDLE can grant the next source on the following cycle.
- Transmitter acceptance latency is up to one baud period. With 6 Mbaud at 24 MHz this is ≤4 clk, well inside `TIMEOUT_CYC`.
- Per payload at 6 Mbaud/24 MHz: 11 bits × 4 clk + handshake overhead. With the header this doubles.

## Test plan
- Single request, `HEADER_EN`=1, `req`=4'b0100, byte 8'h5A:
  - Bytes sent, in order: 8'hA2, then 8'h5A, even parity, framed correctly.
  - `ack`=4'b0100 pulses once. `grant_id`=2 while `active`.
- All four requesting continuously with distinct bytes:
  - Grant order 0,1,2,3,0.
  - Exactly one `ack` bit per completion; no source served twice before the others.
- Transmitter model that never raises `tx_busy`, `TIMEOUT_CYC`=20:
  - `tx_start` is high for exactly 20 cycles, then `err_timeout` pulses.
  - No `ack`. Next grant goes to the next source.
- `reset` low for 1 cycle during the payload BUSY state:
  - All outputs are at reset values on the next edge.
  - A pending request is not granted until `tx_busy` falls. It is then granted to source 0.
- `HEADER_EN`=0, source 1 drops `req` right after LOAD and changes `req_data`:
  - Only the originally latched byte is sent.
  - `ack`=4'b0010 still pulses.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Producer/transmitter-side bundle of the uart_tx_sched block.
// The scheduler connects through the slave modport; producers plus the transmitter use master.
interface uart_tx_sched_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;

  modport slave (
    input  req, req_data, tx_busy,
    output ack, tx_data, tx_start, grant_id, active, err_timeout
  );

  modport master (
    output req, req_data, tx_busy,
    input  ack, tx_data, tx_start, grant_id, active, err_timeout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among four byte producers,
// optionally prefixing each payload byte with a {HDR_TAG, source} header.
module uart_tx_sched #(
  parameter bit          HEADER_EN   = 1'b1,
  parameter logic [5:0]  HDR_TAG     = 6'b101000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic            clk_i,
  input logic            reset_ni,
  uart_tx_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_ACK   = 3'd4
  } state_e;

  typedef enum logic {
    PH_HEADER  = 1'b0,
    PH_PAYLOAD = 1'b1
  } phase_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] payload_q, payload_d;
  logic [3:0] ack_q, ack_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic [1:0] grant_q, grant_d;
  logic       active_q, active_d;
  logic       err_q, err_d;

  // Rotate requests so the source after `last` sits at bit 0, then priority-encode.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] first;
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    first = last + 2'd1;
    dbl   = {req, req} >> first;
    rot   = dbl[3:0];
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    return first + off;
  endfunction

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    payload_d  = payload_q;
    ack_d      = 4'd0;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    grant_d    = grant_q;
    active_d   = active_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A busy transmitter may still be finishing a frame started before a reset.
        if (!bus.tx_busy && (bus.req != 4'd0)) begin
          grant_d  = rr_pick(bus.req, last_q);
          last_d   = grant_d;
          active_d = 1'b1;
          state_d  = S_LOAD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_LOAD: begin
        payload_d  = bus.req_data[{grant_q, 3'b000} +: 8];
        cnt_d      = 8'd0;
        tx_start_d = 1'b1;
        state_d    = S_START;
        if (HEADER_EN) begin
          phase_d   = PH_HEADER;
          tx_data_d = {HDR_TAG, grant_q};
        end else begin
          phase_d   = PH_PAYLOAD;
          tx_data_d = bus.req_data[{grant_q, 3'b000} +: 8];
        end
      end
      S_START: begin
        if (bus.tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = S_BUSY;
        end else if ((cnt_q + 8'd1) == TIMEOUT_LIM) begin
          cnt_d      = cnt_q + 8'd1;
          tx_start_d = 1'b0;
          err_d      = 1'b1;
          active_d   = 1'b0;
          state_d    = S_IDLE;
        end else begin
          cnt_d      = cnt_q + 8'd1;
        end
      end
      S_BUSY: begin
        if (!bus.tx_busy) begin
          if (phase_q == PH_HEADER) begin
            phase_d    = PH_PAYLOAD;
            tx_data_d  = payload_q;
            cnt_d      = 8'd0;
            tx_start_d = 1'b1;
            state_d    = S_START;
          end else begin
            ack_d      = 4'd1 << grant_q;
            state_d    = S_ACK;
          end
        end else begin
          state_d = S_BUSY;
        end
      end
      S_ACK: begin
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        tx_start_d = 1'b0;
        active_d   = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_HEADER;
      last_q     <= 2'd3;
      cnt_q      <= 8'd0;
      payload_q  <= 8'd0;
      ack_q      <= 4'd0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      grant_q    <= 2'd0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      payload_q  <= payload_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      grant_q    <= grant_d;
      active_q   <= active_d;
      err_q      <= err_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.grant_id    = grant_q;
  assign bus.active      = active_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: one header-enabled and one payload-only
// instance, each driving a small transmitter model with random acceptance latency.
module tb_uart_tx_sched;
  localparam int TO    = 20;
  localparam int FRAME = 6;

  logic clk;
  logic [1:0] rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  req_r  [2];
  logic [31:0] data_r [2];
  logic        alive  [2];
  logic        busy_m [2];
  int          wait_m [2];
  int          frame_m[2];

  logic [3:0] ack_v [2];
  logic [7:0] txd_v [2];
  logic       start_v [2];
  logic [1:0] gid_v [2];
  logic       act_v [2];
  logic       err_v [2];

  uart_tx_sched_if bus0 ();
  uart_tx_sched_if bus1 ();

  uart_tx_sched #(.HEADER_EN(1'b1), .HDR_TAG(6'b101000), .TIMEOUT_CYC(TO)) u_hdr (
    .clk_i(clk), .reset_ni(rst_n[0]), .bus(bus0.slave));
  uart_tx_sched #(.HEADER_EN(1'b0), .HDR_TAG(6'b101000), .TIMEOUT_CYC(TO)) u_raw (
    .clk_i(clk), .reset_ni(rst_n[1]), .bus(bus1.slave));

  assign bus0.req = req_r[0];  assign bus0.req_data = data_r[0];  assign bus0.tx_busy = busy_m[0];
  assign bus1.req = req_r[1];  assign bus1.req_data = data_r[1];  assign bus1.tx_busy = busy_m[1];
  assign ack_v[0] = bus0.ack;       assign ack_v[1] = bus1.ack;
  assign txd_v[0] = bus0.tx_data;   assign txd_v[1] = bus1.tx_data;
  assign start_v[0] = bus0.tx_start; assign start_v[1] = bus1.tx_start;
  assign gid_v[0] = bus0.grant_id;  assign gid_v[1] = bus1.grant_id;
  assign act_v[0] = bus0.active;    assign act_v[1] = bus1.active;
  assign err_v[0] = bus0.err_timeout; assign err_v[1] = bus1.err_timeout;

  // Transmitter model: accepts a start after 1..3 cycles, then stays busy for FRAME cycles.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!alive[k]) begin
        busy_m[k] <= 1'b0;
        wait_m[k] <= 0;
      end else if (busy_m[k]) begin
        if (frame_m[k] <= 1) busy_m[k] <= 1'b0;
        frame_m[k] <= frame_m[k] - 1;
      end else if (wait_m[k] > 0) begin
        if (wait_m[k] == 1) begin
          busy_m[k]  <= 1'b1;
          frame_m[k] <= FRAME;
        end
        wait_m[k] <= wait_m[k] - 1;
      end else if (start_v[k]) begin
        wait_m[k] <= int'($urandom_range(3, 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input int k, input string tag);
    chk({tag, "_ack"}, 32'(ack_v[k]), 32'd0);
    chk({tag, "_tx_data"}, 32'(txd_v[k]), 32'd0);
    chk({tag, "_tx_start"}, 32'(start_v[k]), 32'd0);
    chk({tag, "_grant_id"}, 32'(gid_v[k]), 32'd0);
    chk({tag, "_active"}, 32'(act_v[k]), 32'd0);
    chk({tag, "_err"}, 32'(err_v[k]), 32'd0);
  endtask

  task automatic do_reset(input int k);
    rst_n[k] = 1'b0;
    tick();
    tick();
    rst_n[k] = 1'b1;
  endtask

  // Reference arbitration: first requester after `last`, wrapping mod 4.
  function automatic int rr_ref(input int last, input logic [3:0] r);
    for (int s = 1; s <= 4; s++) begin
      if (r[(last + s) % 4]) return (last + s) % 4;
    end
    return -1;
  endfunction

  // One full transfer: grant, bytes accepted by the transmitter, ack or timeout.
  task automatic xfer(input int k, input int exp_lat, input logic [1:0] exp_id,
                      input int exp_n, input logic [7:0] eb0, input logic [7:0] eb1,
                      input logic [3:0] exp_ack, input bit exp_err, input int exp_start,
                      input bit clr, input bit drop);
    int lat, n, start_cnt;
    logic [7:0] got [4];
    bit prev_busy, rose_prev, errv;
    logic [3:0] ackv;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!act_v[k] && lat < 300);
    chk("grant_seen", 32'(act_v[k]), 32'd1);
    if (exp_lat > 0) chk("grant_latency", lat, exp_lat);
    chk("grant_id", 32'(gid_v[k]), 32'(exp_id));
    tick();
    chk("start_after_load", 32'(start_v[k]), 32'd1);
    start_cnt = start_v[k] ? 1 : 0;
    if (drop) begin
      req_r[k]  = 4'd0;
      data_r[k] = ~data_r[k];
    end
    n = 0; ackv = 4'd0; errv = 1'b0; rose_prev = 1'b0; prev_busy = busy_m[k];
    for (int c = 0; c < 400 && ackv == 4'd0 && !errv; c++) begin
      tick();
      if (rose_prev) chk("start_drop", 32'(start_v[k]), 32'd0);
      rose_prev = busy_m[k] && !prev_busy;
      if (rose_prev && n < 4) begin
        got[n] = txd_v[k];
        n++;
      end
      if (start_v[k]) start_cnt++;
      prev_busy = busy_m[k];
      ackv = ack_v[k];
      errv = err_v[k];
    end
    chk("byte_count", n, exp_n);
    if (exp_n >= 1) chk("byte0", 32'(got[0]), 32'(eb0));
    if (exp_n >= 2) chk("byte1", 32'(got[1]), 32'(eb1));
    chk("ack_value", 32'(ackv), 32'(exp_ack));
    chk("err_timeout", 32'(errv), 32'(exp_err));
    if (exp_start > 0) chk("start_cycles", start_cnt, exp_start);
    if (clr) req_r[k] = 4'd0;
    if (errv) chk("inactive_on_err", 32'(act_v[k]), 32'd0);
    if (ackv != 4'd0) begin
      tick();
      chk("ack_one_cycle", 32'(ack_v[k]), 32'd0);
      chk("inactive_after_ack", 32'(act_v[k]), 32'd0);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  exp_id;
    logic [7:0]  exp_hdr;
    logic [7:0]  exp_pay;
    logic [3:0]  exp_ack;
  } vec_t;

  task automatic run_random();
    logic [7:0] exp_q [$];
    int last_m, cur, acks, eid;
    bit prev_act, prev_busy;
    last_m = 3; cur = -1; acks = 0; prev_act = 1'b0; prev_busy = 1'b0;
    for (int c = 0; c < 20000 && acks < 40; c++) begin
      tick();
      if (act_v[0] && !prev_act) begin
        eid = rr_ref(last_m, req_r[0]);
        chk("rnd_grant", 32'(gid_v[0]), 32'(eid));
        last_m = eid; cur = eid;
        exp_q.push_back({6'b101000, 2'(eid)});
        exp_q.push_back(data_r[0][8*eid +: 8]);
      end
      if (busy_m[0] && !prev_busy) begin
        if (exp_q.size() == 0) chk("rnd_extra_byte", 32'd1, 32'd0);
        else chk("rnd_byte", 32'(txd_v[0]), 32'(exp_q.pop_front()));
      end
      if (ack_v[0] != 4'd0) begin
        chk("rnd_ack", 32'(ack_v[0]), (cur >= 0) ? (32'd1 << cur) : 32'd0);
        chk("rnd_bytes_done", exp_q.size(), 0);
        if (cur >= 0) req_r[0][cur] = 1'b0;
        cur = -1;
        acks++;
      end
      if (err_v[0]) chk("rnd_no_err", 32'd1, 32'd0);
      prev_act  = act_v[0];
      prev_busy = busy_m[0];
      for (int s = 0; s < 4; s++) begin
        if (!req_r[0][s] && s != cur && $urandom_range(3, 0) == 0) begin
          req_r[0][s] = 1'b1;
          data_r[0][8*s +: 8] = 8'($urandom);
        end
      end
    end
    chk("rnd_completed", acks, 40);
  endtask

  initial begin
    vec_t vecs [8];
    logic [7:0] rr_pay [4];
    int nb;
    bit pb, bad;

    vecs[0] = '{4'b0100, 32'h115A3344, 2'd2, 8'hA2, 8'h5A, 4'b0100};
    vecs[1] = '{4'b1111, 32'hDEADBEEF, 2'd3, 8'hA3, 8'hDE, 4'b1000};
    vecs[2] = '{4'b0110, 32'h01234567, 2'd1, 8'hA1, 8'h45, 4'b0010};
    vecs[3] = '{4'b1001, 32'h89ABCDEF, 2'd3, 8'hA3, 8'h89, 4'b1000};
    vecs[4] = '{4'b0001, 32'h000000FF, 2'd0, 8'hA0, 8'hFF, 4'b0001};
    vecs[5] = '{4'b1010, 32'h80007E00, 2'd1, 8'hA1, 8'h7E, 4'b0010};
    vecs[6] = '{4'b0101, 32'h005500AA, 2'd2, 8'hA2, 8'h55, 4'b0100};
    vecs[7] = '{4'b0011, 32'hFFFF0001, 2'd0, 8'hA0, 8'h01, 4'b0001};
    rr_pay[0] = 8'h11; rr_pay[1] = 8'h22; rr_pay[2] = 8'h33; rr_pay[3] = 8'h44;

    for (int k = 0; k < 2; k++) begin
      req_r[k] = 4'd0; data_r[k] = 32'd0; alive[k] = 1'b0;
    end
    rst_n = 2'b00;
    repeat (3) tick();
    alive[0] = 1'b1; alive[1] = 1'b1;
    tick();
    chk_reset_vals(0, "reset0");
    chk_reset_vals(1, "reset1");
    rst_n = 2'b11;

    // Arbitration table, starting from the reset value of the round-robin pointer.
    for (int i = 0; i < 8; i++) begin
      req_r[0]  = vecs[i].req;
      data_r[0] = vecs[i].data;
      xfer(0, 1, vecs[i].exp_id, 2, vecs[i].exp_hdr, vecs[i].exp_pay, vecs[i].exp_ack,
           1'b0, 0, 1'b1, 1'b0);
    end

    // All four requesting continuously: grant order 0,1,2,3,0.
    do_reset(0);
    req_r[0] = 4'b1111; data_r[0] = 32'h44332211;
    for (int i = 0; i < 5; i++) begin
      xfer(0, 1, 2'(i % 4), 2, 8'hA0 | 8'(i % 4), rr_pay[i % 4], 4'd1 << (i % 4),
           1'b0, 0, 1'b0, 1'b0);
    end
    req_r[0] = 4'd0;

    // Dead transmitter: timeout, then the next source is served.
    do_reset(0);
    alive[0] = 1'b0;
    req_r[0] = 4'b0011; data_r[0] = 32'h0000B2C1;
    xfer(0, 1, 2'd0, 0, 8'h00, 8'h00, 4'd0, 1'b1, TO, 1'b0, 1'b0);
    req_r[0] = 4'b0010;
    alive[0] = 1'b1;
    xfer(0, 1, 2'd1, 2, 8'hA1, 8'hB2, 4'b0010, 1'b0, 0, 1'b1, 1'b0);

    // Reset pulse during the payload byte while the transmitter stays busy.
    req_r[0] = 4'b0010; data_r[0] = 32'h00009900;
    nb = 0; pb = busy_m[0];
    for (int c = 0; c < 300 && nb < 2; c++) begin
      tick();
      if (busy_m[0] && !pb) nb++;
      pb = busy_m[0];
    end
    chk("rst_setup_bytes", nb, 2);
    tick();
    req_r[0] = 4'b0111; data_r[0] = 32'h0000993C;
    rst_n[0] = 1'b0;
    tick();
    chk_reset_vals(0, "midreset");
    rst_n[0] = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 50 && busy_m[0]; c++) begin
      tick();
      if (act_v[0]) bad = 1'b1;
    end
    chk("no_grant_while_busy", 32'(bad), 32'd0);
    xfer(0, 1, 2'd0, 2, 8'hA0, 8'h3C, 4'b0001, 1'b0, 0, 1'b1, 1'b0);

    // Payload-only instance: requester drops req and changes data after LOAD.
    req_r[1] = 4'b0010; data_r[1] = 32'h0000C700;
    xfer(1, 1, 2'd1, 1, 8'hC7, 8'h00, 4'b0010, 1'b0, 0, 1'b1, 1'b1);
    req_r[1] = 4'b1000; data_r[1] = 32'h6E000000;
    xfer(1, 1, 2'd3, 1, 8'h6E, 8'h00, 4'b1000, 1'b0, 0, 1'b1, 1'b0);

    // Randomised traffic against the reference arbitration model.
    req_r[0] = 4'd0;
    do_reset(0);
    run_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
